btn_event_ctrl: RTL and testbench
=================================

# btn_event_ctrl

Button event controller that sits downstream of the per-button debouncers. It turns N debounced, active-high button levels into discrete PRESS, LONG, REPEAT and RELEASE events. Each button has one pending-event slot; a round-robin arbiter drains the slots into a single valid/ready event stream consumed by the control logic.

## Interface
- `N_BTN`, default 4: number of buttons (≥2).
- `LONG_CYCLES`, default 50_000_000: held cycles before a LONG event (≥2).
- `REPEAT_CYCLES`, default 10_000_000: cycles between REPEAT events after LONG (≥2).
- `clk` in, 1: single clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `btn` in, N_BTN: debounced levels, 1 = pressed, synchronous to `clk`.
- `evt_valid` out, 1: event presented.
- `evt_ready` in, 1: consumer accepts when `evt_valid & evt_ready` at a rising edge.
- `evt_btn` out, $clog2(N_BTN): button index of the event.
- `evt_kind` out, 2: 0 PRESS, 1 LONG, 2 REPEAT, 3 RELEASE.
- `evt_drop` out, 1: one-cycle pulse when a pending event is overwritten or discarded.

## Operation
- Per-button FSM states:
  - LOCKED (reset state): `btn`=0 -> IDLE. No events. A button held through reset is ignored until it is released.
  - IDLE: `btn`=1 -> HELD. Counter cleared, PRESS posted.
  - HELD: `btn`=0 -> IDLE, RELEASE posted. When counter = LONG_CYCLES-1 -> LONG_HELD, counter cleared, LONG posted. Otherwise counter increments.
  - LONG_HELD: `btn`=0 -> IDLE, RELEASE posted. When counter = REPEAT_CYCLES-1, REPEAT posted and counter cleared. Otherwise counter increments.
- Counter width: $clog2(max(LONG_CYCLES, REPEAT_CYCLES)). Counting never wraps; it is always cleared at terminal count.
- Pending slot per button: valid bit plus 2-bit kind.
  - Posting into an empty slot fills it.
  - Posting into a full slot: PRESS, LONG or RELEASE overwrite the slot and pulse `evt_drop`. REPEAT is discarded (slot kept) and pulses `evt_drop`.
  - Posting and granting the same slot in the same cycle: the granted event leaves, the new event occupies the slot, no drop.
- Output register (`evt_valid`, `evt_btn`, `evt_kind`):
  - Loads when empty, or when accepted in this cycle.
  - Source is the first valid slot at or after the round-robin pointer, searching upward with wrap from N_BTN-1 to 0.
  - On a grant, the pointer moves to granted index + 1 (wrapping) and the slot is cleared.
  - With no valid slot, `evt_valid` deasserts when accepted.
- While `evt_valid`=1 and `evt_ready`=0, outputs hold stable.
- `evt_drop` is registered and ORed across buttons.

## Timing
- Reset values:
  - `evt_valid`=0, `evt_btn`=0, `evt_kind`=0, `evt_drop`=0.
  - All FSMs LOCKED, counters 0, slots empty, pointer 0.
- Reset assertion mid-operation clears everything immediately. Pending and presented events are lost.
- `btn` rises, sampled at edge k: slot filled at k, `evt_valid`=1 after edge k+1 (latency 2 edges with `evt_ready`=1 and no contention).
- LONG is posted at edge k+LONG_CYCLES when `btn` stays high from edge k. The first REPEAT follows REPEAT_CYCLES edges later.
- Back-to-back throughput: one event per cycle while `evt_ready`=1.
- `evt_drop` pulses the edge after the offending post.

## Structure
- Package `btn_evt_pkg`:
  - `evt_kind_t` enum (PRESS, LONG, REPEAT, RELEASE).
  - `btn_state_t` enum (LOCKED, IDLE, HELD, LONG_HELD).
- Sub-module `btn_evt_fsm`: one per button via generate. Contains the state, counter and pending slot. Ports: `post_valid`, `post_kind`, `grant`, `pending`, `pending_kind`, `drop`.
- Top level: round-robin arbiter, output register and drop OR.

## Test plan
- Bench parameters: N_BTN=4, LONG_CYCLES=8, REPEAT_CYCLES=4.
- Reset with `btn`=4'b0001 held, release `rst_n`, keep 20 cycles -> no events. Drop `btn[0]`, then raise -> PRESS(0) 2 edges after the rise.
- Hold `btn[2]` 20 cycles, `evt_ready`=1 -> PRESS, then LONG at +8, REPEAT at +12, +16, +20, then RELEASE after the fall. `evt_drop` never pulses.
- `btn`=4'b1111 rising in the same cycle -> PRESS for buttons 0,1,2,3 on consecutive cycles. A second simultaneous burst after the pointer reaches 1 -> order 1,2,3,0.
- `evt_ready`=0 with PRESS(3) presented; pulse `btn[3]` press/release twice -> outputs stable. Slot ends as RELEASE with `evt_drop` pulses. Then `evt_ready`=1 -> PRESS(3), RELEASE(3).
- Hold `btn[1]` into LONG_HELD with `evt_ready`=0 -> REPEAT posts into a full slot, are discarded and pulse `evt_drop`. LONG is retained.
- Assert `rst_n` low while events are pending -> all outputs 0 at once. After release, held buttons stay LOCKED.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// ---------------------------------------------------------------------------
// btn_evt_pkg
//   Shared types for the button event controller.
//   - evt_kind_t  : encoding of the event kind carried on evt_kind
//   - btn_state_t : per-button tracking state
//   - cnt_width() : hold-counter width from the LONG/REPEAT periods
// ---------------------------------------------------------------------------
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_LONG    = 2'd1,
    EVT_REPEAT  = 2'd2,
    EVT_RELEASE = 2'd3
  } evt_kind_t;

  typedef enum logic [1:0] {
    ST_LOCKED    = 2'd0,
    ST_IDLE      = 2'd1,
    ST_HELD      = 2'd2,
    ST_LONG_HELD = 2'd3
  } btn_state_t;

  // The counter only ever reaches max(period)-1, so clog2(max) bits suffice.
  function automatic int unsigned cnt_width(input int unsigned long_cycles,
                                            input int unsigned repeat_cycles);
    int unsigned m;
    m = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
    return $clog2(m);
  endfunction

endpackage : btn_evt_pkg

// File: rtl/btn_evt_fsm.sv
// ---------------------------------------------------------------------------
// btn_evt_fsm
//   Per-button tracker: turns one debounced level into PRESS / LONG /
//   REPEAT / RELEASE posts and holds at most one pending event in a slot.
//
//   Ports
//     clk, rst_n    : clock, async active-low reset
//     btn           : debounced level, 1 = pressed
//     grant         : arbiter takes the pending event at this edge
//     pending       : slot holds an event
//     pending_kind  : kind of the pending event
//     drop          : an event is lost at this edge (unregistered)
// ---------------------------------------------------------------------------
module btn_evt_fsm
  import btn_evt_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       grant,
  output logic       pending,
  output logic [1:0] pending_kind,
  output logic       drop
);

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slot_vld_q, slot_vld_d;
  evt_kind_t        slot_kind_q, slot_kind_d;

  logic             post_valid;
  evt_kind_t        post_kind;
  logic             slot_busy;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOCKED;
      cnt_q       <= '0;
      slot_vld_q  <= 1'b0;
      slot_kind_q <= EVT_PRESS;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_vld_q  <= slot_vld_d;
      slot_kind_q <= slot_kind_d;
    end
  end

  // Next-state and hold counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_LOCKED: begin
        if (!btn) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (btn) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end
      end
      ST_HELD: begin
        if (!btn) begin
          state_d = ST_IDLE;
        end else if (cnt_q == LONG_TC) begin
          state_d = ST_LONG_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (!btn) begin
          state_d = ST_IDLE;
        end else if (cnt_q == REPEAT_TC) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_LOCKED;
    endcase
  end

  // Event posts (Mealy: depend on the current btn sample)
  always_comb begin
    post_valid = 1'b0;
    post_kind  = EVT_PRESS;
    unique case (state_q)
      ST_IDLE: begin
        if (btn) begin
          post_valid = 1'b1;
          post_kind  = EVT_PRESS;
        end
      end
      ST_HELD: begin
        if (!btn) begin
          post_valid = 1'b1;
          post_kind  = EVT_RELEASE;
        end else if (cnt_q == LONG_TC) begin
          post_valid = 1'b1;
          post_kind  = EVT_LONG;
        end
      end
      ST_LONG_HELD: begin
        if (!btn) begin
          post_valid = 1'b1;
          post_kind  = EVT_RELEASE;
        end else if (cnt_q == REPEAT_TC) begin
          post_valid = 1'b1;
          post_kind  = EVT_REPEAT;
        end
      end
      default: ;
    endcase
  end

  // Pending slot. A slot being granted this edge counts as free, so a
  // simultaneous post simply takes its place without a drop.
  always_comb begin
    slot_busy   = slot_vld_q && !grant;
    slot_vld_d  = slot_vld_q;
    slot_kind_d = slot_kind_q;
    drop        = 1'b0;
    if (post_valid) begin
      if (slot_busy && (post_kind == EVT_REPEAT)) begin
        drop = 1'b1;
      end else begin
        slot_vld_d  = 1'b1;
        slot_kind_d = post_kind;
        drop        = slot_busy;
      end
    end else if (grant) begin
      slot_vld_d = 1'b0;
    end
  end

  assign pending      = slot_vld_q;
  assign pending_kind = slot_kind_q;

endmodule : btn_evt_fsm

// File: rtl/btn_event_ctrl.sv
// ---------------------------------------------------------------------------
// btn_event_ctrl
//   Converts N debounced button levels into a single valid/ready stream of
//   PRESS / LONG / REPEAT / RELEASE events, one pending slot per button,
//   drained by a round-robin arbiter into a registered output stage.
//
//   Ports
//     clk, rst_n : clock, async active-low reset
//     btn        : debounced levels, 1 = pressed
//     evt_valid  : event presented
//     evt_ready  : consumer accepts on evt_valid & evt_ready
//     evt_btn    : index of the button the event belongs to
//     evt_kind   : 0 PRESS, 1 LONG, 2 REPEAT, 3 RELEASE
//     evt_drop   : one-cycle pulse when a pending event was lost
// ---------------------------------------------------------------------------
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_btn,
  output logic [1:0]               evt_kind,
  output logic                     evt_drop
);

  localparam int unsigned IDX_W = $clog2(N_BTN);
  localparam int unsigned CNT_W = cnt_width(LONG_CYCLES, REPEAT_CYCLES);

  logic [N_BTN-1:0] pending;
  logic [1:0]       pending_kind [N_BTN];
  logic [N_BTN-1:0] drop;
  logic [N_BTN-1:0] grant;

  logic             load;
  logic             found;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] ptr_next;
  int unsigned      scan_idx;

  logic             evt_valid_q;
  logic [IDX_W-1:0] evt_btn_q;
  logic [1:0]       evt_kind_q;
  logic             evt_drop_q;
  logic [IDX_W-1:0] ptr_q;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_evt_fsm #(
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn         (btn[g]),
      .grant       (grant[g]),
      .pending     (pending[g]),
      .pending_kind(pending_kind[g]),
      .drop        (drop[g])
    );
  end

  // The output stage takes a new event whenever it is empty or being drained.
  assign load = !evt_valid_q || evt_ready;

  // Round-robin search: first pending slot at or after ptr_q, wrapping.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    cand     = '0;
    scan_idx = 0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      scan_idx = i + {{(32-IDX_W){1'b0}}, ptr_q};
      if (scan_idx >= N_BTN) scan_idx = scan_idx - N_BTN;
      cand = IDX_W'(scan_idx);
      if (!found && pending[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (load && found) grant[sel] = 1'b1;
  end

  assign ptr_next = (sel == IDX_W'(N_BTN - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_btn_q   <= '0;
      evt_kind_q  <= '0;
      evt_drop_q  <= 1'b0;
      ptr_q       <= '0;
    end else begin
      evt_drop_q <= |drop;
      if (load) begin
        if (found) begin
          evt_valid_q <= 1'b1;
          evt_btn_q   <= sel;
          evt_kind_q  <= pending_kind[sel];
          ptr_q       <= ptr_next;
        end else begin
          evt_valid_q <= 1'b0;
        end
      end
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_btn   = evt_btn_q;
  assign evt_kind  = evt_kind_q;
  assign evt_drop  = evt_drop_q;

endmodule : btn_event_ctrl

// File: tb/tb_btn_event_ctrl.sv
// ---------------------------------------------------------------------------
// tb_btn_event_ctrl
//   Directed bench for btn_event_ctrl with N_BTN=4, LONG_CYCLES=8,
//   REPEAT_CYCLES=4. Edge k below is the first clock edge that samples a
//   new btn value; outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_btn_event_ctrl;
  import btn_evt_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_btn;
  logic [1:0] evt_kind;
  logic       evt_drop;

  int tests;
  int fails;

  btn_event_ctrl #(
    .N_BTN        (4),
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_btn  (evt_btn),
    .evt_kind (evt_kind),
    .evt_drop (evt_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input logic v, input logic [1:0] b, input logic [1:0] k);
    chk({tag, "_valid"}, {31'd0, evt_valid}, {31'd0, v});
    if (v) begin
      chk({tag, "_btn"},  {30'd0, evt_btn},  {30'd0, b});
      chk({tag, "_kind"}, {30'd0, evt_kind}, {30'd0, k});
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    btn   = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [1:0] ord [4];
    logic       pat [5];
    logic       dexp [5];
    logic       ev;
    logic [1:0] ek;

    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    btn       = 4'b0001;
    evt_ready = 1'b1;

    // Reset values, button 0 held through reset
    tick(); tick(); tick();
    chk("rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_btn",   {30'd0, evt_btn},   32'd0);
    chk("rst_kind",  {30'd0, evt_kind},  32'd0);
    chk("rst_drop",  {31'd0, evt_drop},  32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("locked_quiet", {31'd0, evt_valid}, 32'd0);
    end
    btn = 4'b0000; tick();
    btn = 4'b0001; tick();
    chk("s1_lat1", {31'd0, evt_valid}, 32'd0);
    tick();
    chk_evt("s1_press", 1'b1, 2'd0, EVT_PRESS);
    btn = 4'b0000; tick();
    chk("s1_accepted", {31'd0, evt_valid}, 32'd0);
    tick();
    chk_evt("s1_release", 1'b1, 2'd0, EVT_RELEASE);
    tick();
    chk("s1_empty", {31'd0, evt_valid}, 32'd0);

    // Long hold of button 2: PRESS, LONG, 3x REPEAT, RELEASE
    btn = 4'b0100;
    for (int c = 0; c <= 24; c++) begin
      tick();
      ev = 1'b0;
      ek = EVT_PRESS;
      case (c)
        1:          begin ev = 1'b1; ek = EVT_PRESS;   end
        9:          begin ev = 1'b1; ek = EVT_LONG;    end
        13, 17, 21: begin ev = 1'b1; ek = EVT_REPEAT;  end
        23:         begin ev = 1'b1; ek = EVT_RELEASE; end
        default: ;
      endcase
      chk_evt("s2_hold", ev, 2'd2, ek);
      chk("s2_nodrop", {31'd0, evt_drop}, 32'd0);
      if (c == 21) btn = 4'b0000;
    end

    // Simultaneous bursts, pointer at 0 then at 1
    reset_dut();
    btn = 4'b1111; tick();
    chk("s3_lat1", {31'd0, evt_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_evt("s3_burst_press", 1'b1, 2'(i), EVT_PRESS);
    end
    tick();
    chk("s3_drained", {31'd0, evt_valid}, 32'd0);
    btn = 4'b0000; tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_evt("s3_burst_release", 1'b1, 2'(i), EVT_RELEASE);
    end
    tick();
    btn = 4'b0001; tick(); tick();
    chk_evt("s3_ptr_press", 1'b1, 2'd0, EVT_PRESS);
    btn = 4'b0000; tick(); tick();
    chk_evt("s3_ptr_release", 1'b1, 2'd0, EVT_RELEASE);
    tick();
    chk("s3_ptr_empty", {31'd0, evt_valid}, 32'd0);
    ord[0] = 2'd1; ord[1] = 2'd2; ord[2] = 2'd3; ord[3] = 2'd0;
    btn = 4'b1111; tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_evt("s3_rr_order", 1'b1, ord[i], EVT_PRESS);
    end

    // Back-pressure with overwrites on button 3
    reset_dut();
    evt_ready = 1'b0;
    btn = 4'b1000; tick(); tick();
    chk_evt("s4_press", 1'b1, 2'd3, EVT_PRESS);
    pat[0] = 1'b0; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b0;
    dexp[0] = 1'b0; dexp[1] = 1'b1; dexp[2] = 1'b1; dexp[3] = 1'b1; dexp[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      btn[3] = pat[i];
      tick();
      chk_evt("s4_stable", 1'b1, 2'd3, EVT_PRESS);
      chk("s4_drop", {31'd0, evt_drop}, {31'd0, dexp[i]});
    end
    tick();
    chk("s4_drop_end", {31'd0, evt_drop}, 32'd0);
    chk_evt("s4_stable_end", 1'b1, 2'd3, EVT_PRESS);
    evt_ready = 1'b1;
    tick();
    chk_evt("s4_release", 1'b1, 2'd3, EVT_RELEASE);
    tick();
    chk("s4_empty", {31'd0, evt_valid}, 32'd0);

    // REPEAT into a full slot while stalled on button 1
    reset_dut();
    evt_ready = 1'b0;
    btn = 4'b0010; tick();
    chk("s5_lat1", {31'd0, evt_valid}, 32'd0);
    for (int c = 1; c <= 17; c++) begin
      tick();
      chk_evt("s5_stable", 1'b1, 2'd1, EVT_PRESS);
      chk("s5_drop", {31'd0, evt_drop}, {31'd0, (c == 12 || c == 16)});
    end
    evt_ready = 1'b1; tick();
    chk_evt("s5_long_kept", 1'b1, 2'd1, EVT_LONG);
    evt_ready = 1'b0; tick(); tick();
    chk_evt("s5_long_hold", 1'b1, 2'd1, EVT_LONG);
    chk("s5_nodrop", {31'd0, evt_drop}, 32'd0);

    // Asynchronous reset with events pending, button 1 still held
    rst_n = 1'b0;
    #1;
    chk("s6_valid", {31'd0, evt_valid}, 32'd0);
    chk("s6_btn",   {30'd0, evt_btn},   32'd0);
    chk("s6_kind",  {30'd0, evt_kind},  32'd0);
    chk("s6_drop",  {31'd0, evt_drop},  32'd0);
    tick(); tick();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("s6_locked", {31'd0, evt_valid}, 32'd0);
    end
    btn = 4'b0000; tick();
    btn = 4'b0010; tick(); tick();
    chk_evt("s6_press", 1'b1, 2'd1, EVT_PRESS);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_btn_event_ctrl
